// File: rtl/dma_controller_pkg.sv
// dma_controller_pkg: shared DMA constants and the transfer FSM state encoding.
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_BLOCK_WORDS = 12;
  localparam int DMA_CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: base-address register and acknowledged-word counter; the write
// address is the modular sum of the two, so it wraps naturally at the top of memory.
module dma_addr_gen
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] base_addr,
  input  logic                 incr,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [DMA_CNT_W-1:0] dma_counter
);

  logic [WORD_SIZE-1:0] base_q;
  logic [DMA_CNT_W-1:0] cnt_q;

  // Latch base and clear count on start; step count once per acknowledged write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      base_q <= base_addr;
      cnt_q  <= '0;
    end else if (incr) begin
      cnt_q  <= cnt_q + DMA_CNT_W'(1);
    end
  end

  assign mem_addr    = base_q + WORD_SIZE'(cnt_q);
  assign dma_counter = cnt_q;

endmodule

// File: rtl/dma_controller.sv
// dma_controller: bus-master engine copying BLOCK_WORDS device words into memory
// after winning the BR/BG handshake; freezes in place whenever the grant is withdrawn.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int BLOCK_WORDS = DMA_BLOCK_WORDS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 busy,
  output logic                 BR,
  input  logic                 BG,
  input  logic                 dev_valid,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_write,
  input  logic                 mem_ack,
  output logic [DMA_CNT_W-1:0] dma_counter,
  output logic                 dma_end
);

  localparam logic [DMA_CNT_W:0] LAST_CNT = (DMA_CNT_W+1)'(BLOCK_WORDS);

  dma_state_e           state_q;
  dma_state_e           state_d;
  logic [WORD_SIZE-1:0] hold_q;
  logic                 end_q;
  logic                 load;
  logic                 accept;
  logic                 incr;
  logic [DMA_CNT_W:0]   cnt_next;

  assign load     = (state_q == ST_IDLE) && cmd_start;
  assign accept   = dev_ready && dev_valid;
  assign incr     = mem_write && mem_ack;
  assign cnt_next = {1'b0, dma_counter} + (DMA_CNT_W+1)'(1);

  dma_addr_gen #(
    .WORD_SIZE (WORD_SIZE)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .base_addr   (cmd_addr),
    .incr        (incr),
    .mem_addr    (mem_addr),
    .dma_counter (dma_counter)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a withdrawn grant simply blocks the FETCH/WRITE exits
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_start) state_d = ST_REQUEST;
      ST_REQUEST: if (BG)        state_d = ST_FETCH;
      ST_FETCH:   if (accept)    state_d = ST_WRITE;
      ST_WRITE:   if (incr)      state_d = (cnt_next == LAST_CNT) ? ST_DONE : ST_FETCH;
      ST_DONE:    if (!BG)       state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State decodes; BG gating is the only input-to-output path
  always_comb begin
    BR        = 1'b0;
    busy      = 1'b0;
    dev_ready = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_REQUEST: begin
        BR   = 1'b1;
        busy = 1'b1;
      end
      ST_FETCH: begin
        BR        = 1'b1;
        busy      = 1'b1;
        dev_ready = BG;
      end
      ST_WRITE: begin
        BR        = 1'b1;
        busy      = 1'b1;
        mem_write = BG;
      end
      ST_DONE:  busy = 1'b1;
      default: ;
    endcase
  end

  // Holding register keeps the accepted word stable for the whole write handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    hold_q <= '0;
    else if (accept) hold_q <= dev_data;
  end

  // Completion pulse marks only the first DONE cycle, however long BG lingers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) end_q <= 1'b0;
    else          end_q <= (state_q == ST_WRITE) && (state_d == ST_DONE);
  end

  assign mem_data = hold_q;
  assign dma_end  = end_q;

endmodule
